// File: rtl/blk_mem_gen_pkg.sv
// Shared sizing constants and power-up content tables for the operand RAMs.
// Set A holds half-precision 1.0 + i/16 and set B holds 2.0 + i/8.
package blk_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic INIT_SET_A = 1'b0;
  localparam logic INIT_SET_B = 1'b1;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t             table_t [DEPTH];

  // The mantissa step sits at bit 6, so the index fills mantissa bits [9:6].
  function automatic word_t init_word(input logic sel, input int idx);
    word_t base;
    word_t step;
    base = (sel == INIT_SET_B) ? 16'h4000 : 16'h3C00;
    step = word_t'(idx) << 6;
    return base | step;
  endfunction

  function automatic table_t init_table(input logic sel);
    table_t t;
    for (int i = 0; i < DEPTH; i++) begin
      t[i] = init_word(sel, i);
    end
    return t;
  endfunction

endpackage

// File: rtl/blk_mem_gen_if.sv
// Single-port RAM access bus. The master holds ena/wea/addra/dina for one
// edge per access; douta carries the addressed word one edge later.
interface blk_mem_gen_if #(
  parameter int DATA_W = blk_mem_pkg::DATA_W,
  parameter int ADDR_W = blk_mem_pkg::ADDR_W
);

  // Access protocol: there is no ready. Every edge with ena=1 is an accepted
  // access (write when wea=1, read-first). With ena=0 nothing happens and
  // douta keeps its previous value.
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport master (
    output ena,
    output wea,
    output addra,
    output dina,
    input  douta
  );

  modport slave (
    input  ena,
    input  wea,
    input  addra,
    input  dina,
    output douta
  );

endinterface

// File: rtl/blk_mem_gen.sv
// Single-port synchronous RAM with read-first writes, one-cycle registered
// read data and a preloaded operand table chosen by INIT_SEL.
module blk_mem_gen
  import blk_mem_pkg::*;
#(
  parameter int   DATA_W   = blk_mem_pkg::DATA_W,
  parameter int   ADDR_W   = blk_mem_pkg::ADDR_W,
  parameter logic INIT_SEL = INIT_SET_A
) (
  input  logic                 clka,
  input  logic                 rsta,
  blk_mem_gen_if.slave         bus
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] mem_t [MEM_DEPTH];

  function automatic mem_t build_table(input logic sel);
    mem_t t;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      t[i] = DATA_W'(init_word(sel, i));
    end
    return t;
  endfunction

  // Contents come from the declaration so that reset never touches the array.
  mem_t mem = build_table(INIT_SEL);

  logic [DATA_W-1:0] douta_q;
  logic              wr_en;
  logic              rd_en;

  assign wr_en = bus.ena && bus.wea && !rsta;
  assign rd_en = bus.ena;

  always_ff @(posedge clka) begin
    if (wr_en) begin
      mem[bus.addra] <= bus.dina;
    end
  end

  // Sampling the array before the write lands gives read-first behaviour.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      douta_q <= '0;
    end else if (rd_en) begin
      douta_q <= mem[bus.addra];
    end
  end

  assign bus.douta = douta_q;

endmodule

// File: tb/tb_blk_mem_gen.sv
// Self-checking bench: operand sources A and B share one address stream,
// checked by directed tables, reset sequences and a random model run.
module tb_blk_mem_gen;

  logic clk;
  logic rst;

  blk_mem_gen_if #(.DATA_W(16), .ADDR_W(4)) bus_a ();
  blk_mem_gen_if #(.DATA_W(16), .ADDR_W(4)) bus_b ();

  blk_mem_gen #(.DATA_W(16), .ADDR_W(4), .INIT_SEL(1'b0)) dut_a (
    .clka (clk),
    .rsta (rst),
    .bus  (bus_a.slave)
  );

  blk_mem_gen #(.DATA_W(16), .ADDR_W(4), .INIT_SEL(1'b1)) dut_b (
    .clka (clk),
    .rsta (rst),
    .bus  (bus_b.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // reference model: plain word arrays plus the last value seen on each port
  logic [15:0] ma [16];
  logic [15:0] mb [16];
  logic [15:0] last_a;
  logic [15:0] last_b;
  logic [15:0] exp_q [$];

  typedef struct {
    logic        ena;
    logic        wea;
    logic [3:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    string       name;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    last_a = 16'h0000;
    last_b = 16'h0000;
  endtask

  task automatic model_step(input logic e, input logic w, input logic [3:0] a, input logic [15:0] d);
    if (e) begin
      last_a = ma[a];
      last_b = mb[a];
      if (w) begin
        ma[a] = d;
        mb[a] = d;
      end
    end
    exp_q.push_back(last_a);
    exp_q.push_back(last_b);
  endtask

  // driver: inputs change 1 time unit after the rising edge, outputs sampled there too
  task automatic drive(input logic e, input logic w, input logic [3:0] a, input logic [15:0] d);
    bus_a.ena = e;  bus_b.ena = e;
    bus_a.wea = w;  bus_b.wea = w;
    bus_a.addra = a; bus_b.addra = a;
    bus_a.dina = d; bus_b.dina = d;
  endtask

  task automatic access(input logic e, input logic w, input logic [3:0] a, input logic [15:0] d,
                        output logic [15:0] qa, output logic [15:0] qb);
    drive(e, w, a, d);
    model_step(e, w, a, d);
    @(posedge clk);
    #1;
    qa = bus_a.douta;
    qb = bus_b.douta;
  endtask

  // async reset asserted between edges, held across one edge with a write offered
  task automatic reset_pulse(input logic [3:0] a, input logic [15:0] d, input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_async_a"}, bus_a.douta, 16'h0000);
    check({tag, "_async_b"}, bus_b.douta, 16'h0000);
    model_reset();
    drive(1'b1, 1'b1, a, d);
    @(posedge clk);
    #1;
    check({tag, "_held_a"}, bus_a.douta, 16'h0000);
    check({tag, "_held_b"}, bus_b.douta, 16'h0000);
    #2;
    rst = 1'b0;
    #1;
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
  endtask

  logic [15:0] qa;
  logic [15:0] qb;
  logic [15:0] ea;
  logic [15:0] eb;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 16; i++) begin
      ma[i] = 16'(16'h3C00 + i * 64);
      mb[i] = 16'(16'h4000 + i * 64);
    end
    model_reset();

    vecs.push_back('{1'b1, 1'b0, 4'd5,  16'h0000, 16'h3D40, 16'h4140, "rd5"});
    vecs.push_back('{1'b1, 1'b1, 4'd3,  16'hBC00, 16'h3CC0, 16'h40C0, "wr3_read_first"});
    vecs.push_back('{1'b1, 1'b0, 4'd3,  16'h0000, 16'hBC00, 16'hBC00, "rd3_after_wr"});
    vecs.push_back('{1'b0, 1'b1, 4'd7,  16'hFFFF, 16'hBC00, 16'hBC00, "hold_ena0"});
    vecs.push_back('{1'b1, 1'b0, 4'd7,  16'h0000, 16'h3DC0, 16'h41C0, "rd7_unwritten"});
    vecs.push_back('{1'b1, 1'b0, 4'd14, 16'h0000, 16'h3F80, 16'h4380, "wrap14"});
    vecs.push_back('{1'b1, 1'b0, 4'd15, 16'h0000, 16'h3FC0, 16'h43C0, "wrap15"});
    vecs.push_back('{1'b1, 1'b0, 4'd0,  16'h0000, 16'h3C00, 16'h4000, "wrap0"});
    vecs.push_back('{1'b1, 1'b0, 4'd1,  16'h0000, 16'h3C40, 16'h4040, "wrap1"});

    // reset state
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    #1;
    check("reset_a", bus_a.douta, 16'h0000);
    check("reset_b", bus_b.douta, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_a", bus_a.douta, 16'h0000);
    rst = 1'b0;

    // full sweep of both initial tables
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 1'b0, 4'(i), 16'h0000, qa, qb);
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      check($sformatf("sweep_a%0d", i), qa, 16'h3C00 | 16'(i * 64));
      check($sformatf("sweep_b%0d", i), qb, 16'h4000 | 16'(i * 64));
    end

    // directed vectors
    for (int k = 0; k < vecs.size(); k++) begin
      access(vecs[k].ena, vecs[k].wea, vecs[k].addr, vecs[k].din, qa, qb);
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      check({vecs[k].name, "_a"}, qa, vecs[k].exp_a);
      check({vecs[k].name, "_b"}, qb, vecs[k].exp_b);
    end

    // mid-stream async reset: contents survive, write during reset is dropped
    access(1'b1, 1'b0, 4'd8, 16'h0000, qa, qb);
    ea = exp_q.pop_front();
    eb = exp_q.pop_front();
    check("pre_rst_rd8_a", qa, 16'h3E00);
    reset_pulse(4'd8, 16'h1234, "midrst");
    access(1'b1, 1'b0, 4'd8, 16'h0000, qa, qb);
    ea = exp_q.pop_front();
    eb = exp_q.pop_front();
    check("post_rst_rd8_a", qa, 16'h3E00);
    check("post_rst_rd8_b", qb, 16'h4200);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset_pulse(4'($urandom_range(0, 15)), 16'($urandom), $sformatf("rnd_rst%0d", n));
      end else begin
        access($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
               4'($urandom_range(0, 15)), 16'($urandom), qa, qb);
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        check($sformatf("rnd%0d_a", n), qa, ea);
        check($sformatf("rnd%0d_b", n), qb, eb);
      end
    end

    // final readback of every word
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 1'b0, 4'(i), 16'h0000, qa, qb);
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      check($sformatf("final_a%0d", i), qa, ea);
      check($sformatf("final_b%0d", i), qb, eb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/blk_mem_gen.md
BLK_MEM_GEN -- requirements
Module: blk_mem_gen

Interface
REQ-001 The parameter DATA_W SHALL default to 16 and set the data word width in bits.
REQ-002 The parameter ADDR_W SHALL default to 4 and set the address width, giving DEPTH = 2**ADDR_W = 16 words.
REQ-003 The parameter INIT_SEL SHALL default to 0 and select the power-up content table: 0 for operand set A, 1 for operand set B.
REQ-004 Port clka SHALL be a 1-bit input and the single clock; all logic is rising-edge triggered.
REQ-005 Port rsta SHALL be a 1-bit input, an asynchronous active-high reset.
REQ-006 Port ena SHALL be a 1-bit input, the port enable; with ena low there is no read and no write.
REQ-007 Port wea SHALL be a 1-bit input, the write enable; it is qualified by ena.
REQ-008 Port addra SHALL be an ADDR_W-bit input, the word address.
REQ-009 Port dina SHALL be a DATA_W-bit input, the write data.
REQ-010 Port douta SHALL be a DATA_W-bit registered output, the read data.

Function
REQ-011 The block SHALL be a single-port synchronous RAM of DEPTH x DATA_W bits.
REQ-012 With INIT_SEL=0, the initial contents SHALL be mem[i] = 16'h3C00 | (i<<6), which is IEEE half 1.0 + i/16; for example mem[0]=16'h3C00 and mem[15]=16'h3FC0.
REQ-013 With INIT_SEL=1, the initial contents SHALL be mem[i] = 16'h4000 | (i<<6), which is IEEE half 2.0 + i/8; for example mem[0]=16'h4000 and mem[15]=16'h43C0.
REQ-014 The read latency SHALL be one cycle: addra sampled at edge N with ena=1 appears on douta after edge N.
REQ-015 On a write (ena=1, wea=1), mem[addra] SHALL take dina at the clock edge.
REQ-016 Writes SHALL be read-first: douta shows the word held before the write.
REQ-017 With ena=0, douta SHALL hold its value and memory SHALL be unchanged, regardless of wea, addra and dina.
REQ-018 The address SHALL be used unsigned over the full 0..15 range with no out-of-range case, so a sequencing master wraps 15 -> 0 naturally.
REQ-019 Back-to-back accesses SHALL run at one per cycle with no stall or bubble.
REQ-020 Write data SHALL be visible to a read of the same address on the cycle after the write.

Reset
REQ-021 Asserting rsta SHALL clear douta to 16'h0000 immediately, without waiting for a clock edge.
REQ-022 douta SHALL hold 16'h0000 for as long as rsta is high.
REQ-023 rsta SHALL NOT alter the memory contents.
REQ-024 Writes presented while rsta is high SHALL be ignored.
REQ-025 A reset in the middle of a sequence SHALL lose only the pending douta value.
REQ-026 On the first edge after rsta deasserts, the block SHALL resume normal one-cycle reads.

Structure
REQ-027 Package blk_mem_pkg SHALL hold DATA_W, ADDR_W, DEPTH and a constant function that returns the initial table for a given INIT_SEL.
REQ-028 The block SHALL be a single module with no sub-modules; the memory array and output register are inferred.
REQ-029 One instance with INIT_SEL=0 SHALL serve as operand source A and one with INIT_SEL=1 as operand source B; both share one address counter.

Verification
REQ-030 Reset then read: rsta pulsed, then addra=0..15 with ena=1 and INIT_SEL=0 -> douta sequence 3C00, 3C40, ..., 3FC0, one cycle after each address.
REQ-031 Set B read: INIT_SEL=1, addra=5 -> douta=16'h4140 one cycle later.
REQ-032 Write then read: ena=1, wea=1, addra=3, dina=16'hBC00 -> douta=16'h3CC0 (read-first); the next read of addr 3 -> 16'hBC00.
REQ-033 Hold: ena=0 with wea=1, addra=7, dina=16'hFFFF -> douta unchanged, and a later read of addr 7 -> 16'h3DC0.
REQ-034 Async reset mid-stream: rsta raised between edges while douta=16'h3E00 -> douta=16'h0000 at once; after release, a read of addr 8 -> 16'h3E00 (contents intact).
REQ-035 Wrap: a free-running address 14, 15, 0, 1 -> douta 3F80, 3FC0, 3C00, 3C40 with no gap.
